imem_loader: RTL

- Writable replacement for the fixed 16x8 instruction ROM of the K2 core.
- Accepts a length-prefixed byte stream over a valid/ready interface and writes it into a 16-entry flop-based program store.
- Pads the unwritten locations with the idle instruction.
- Serves the core's combinational fetch port (4-bit addr in, 8-bit inst out) and holds the core until a load completes.

---
 rtl/imem_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: writable 16x8 program store for the K2 core.
// A length-prefixed byte stream is written into a flop-based store. Locations
// past the loaded program are padded with the idle instruction. The core is
// held, and sees the idle instruction, until a load completes.
module imem_loader #(
    parameter int              DEPTH     = 16,
    parameter int              AW        = 4,
    parameter int              IW        = 8,
    parameter logic [IW-1:0]   IDLE_INST = 8'b00110000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic [IW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] addr,
    output logic [IW-1:0] inst,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   load_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_FILL,
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [IW-1:0] r_mem [DEPTH];
    // wptr carries one extra bit so that it can reach DEPTH without wrapping.
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_len;
    logic [AW:0]   r_count;

    logic          w_xfer;
    logic          w_len_ok;
    logic          w_last_data;
    logic          w_last_fill;
    logic          w_len_full;
    logic          w_we;
    logic [IW-1:0] w_wdata;

    assign w_xfer      = in_valid && in_ready;
    assign w_len_ok    = (in_data != '0) && (in_data <= IW'(DEPTH));
    assign w_last_data = ((r_wptr + (AW+1)'(1)) == r_len);
    assign w_last_fill = (r_wptr == (AW+1)'(DEPTH - 1));
    assign w_len_full  = (r_len == (AW+1)'(DEPTH));

    assign in_ready    = (r_state == S_LEN) || (r_state == S_DATA);
    assign cpu_hold    = (r_state != S_DONE);
    assign load_done   = (r_state == S_DONE);
    assign load_err    = (r_state == S_ERR);
    assign load_count  = r_count;

    // Fetch port: idle instruction while the core is held.
    assign inst = cpu_hold ? IDLE_INST : r_mem[addr];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and store write strobe.
    always_comb begin
        w_next  = r_state;
        w_we    = 1'b0;
        w_wdata = in_data;
        case (r_state)
            S_IDLE: begin
                if (load_start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_xfer) w_next = w_len_ok ? S_DATA : S_ERR;
            end
            S_DATA: begin
                if (w_xfer) begin
                    w_we = 1'b1;
                    if (w_last_data) w_next = w_len_full ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                w_we    = 1'b1;
                w_wdata = IDLE_INST;
                if (w_last_fill) w_next = S_DONE;
            end
            S_DONE: begin
                if (load_start) w_next = S_LEN;
            end
            S_ERR: begin
                if (load_start) w_next = S_LEN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Length latch, write pointer and written-word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len   <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_LEN: begin
                    if (w_xfer && w_len_ok) begin
                        r_len   <= in_data[AW:0];
                        r_wptr  <= '0;
                        r_count <= '0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_wptr  <= r_wptr + (AW+1)'(1);
                        r_count <= r_count + (AW+1)'(1);
                    end
                end
                S_FILL: begin
                    r_wptr <= r_wptr + (AW+1)'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Program store; reset clears every entry to the idle instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= IDLE_INST;
        end else if (w_we) begin
            r_mem[r_wptr[AW-1:0]] <= w_wdata;
        end
    end

endmodule
